jtag_scan_ctrl: RTL and testbench

Self-clocked JTAG master that sequences the SoC's 5-wire JTAG port (TCK/TMS/TDI/TDO/TRST_N) from a simple request/response interface. It generates TCK as a divided version of clock_i and walks the TAP state machine for IR scans, DR scans and TAP resets. It sits in place of the jtagdpi model, driving the azadi_soc_top jtag_* pins, so debug transactions can be issued from on-chip or testbench logic without an external debugger.

---
 rtl/jtag_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_jtag_scan_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_ctrl.sv
// Self-clocked JTAG master: divides clock_i into TCK and walks the TAP through
// IR scans, DR scans and TAP resets on behalf of a request/response interface.
module jtag_scan_ctrl #(
  parameter  int MAX_LEN = 64,
  parameter  int CLK_DIV = 4,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_reset_i,
  input  logic               req_is_ir_i,
  input  logic [LW-1:0]      req_len_i,
  input  logic [MAX_LEN-1:0] req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  output logic               jtag_trst_no,
  input  logic               jtag_tdo_i
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = (IW > 3) ? IW : 3;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_INIT_RST, S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RSP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;
  logic               is_ir_q, is_ir_d;
  logic               rst_req_q, rst_req_d;
  logic               err_q, err_d;
  logic [CW-1:0]      len_m1_q, len_m1_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    tck_d     = tck_q;
    is_ir_d   = is_ir_q;
    rst_req_d = rst_req_q;
    err_d     = err_q;
    len_m1_d  = len_m1_q;
    data_d    = data_q;
    cap_d     = cap_q;
    tms_d     = 1'b0;
    tdi_d     = 1'b0;
    trst_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cnt_d     = '0;
          div_d     = '0;
          tck_d     = 1'b0;
          cap_d     = '0;
          err_d     = 1'b0;
          data_d    = req_data_i;
          is_ir_d   = req_is_ir_i;
          rst_req_d = req_reset_i;
          len_m1_d  = CW'(req_len_i - LW'(1));
          if (req_reset_i) begin
            state_d = S_INIT_RST;
          end else if (req_len_i == '0 || req_len_i > LW'(MAX_LEN)) begin
            state_d = S_RSP;
            err_d   = 1'b1;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: begin
        if (div_q != DW'(CLK_DIV - 1)) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            if (state_q == S_SHIFT) cap_d[cnt_q[IW-1:0]] = jtag_tdo_i;
          end else begin
            // End of a high phase: step to the next TMS/TDI slot.
            cnt_d = cnt_q + 1'b1;
            case (state_q)
              S_INIT_RST: if (cnt_q == CW'(5)) state_d = rst_req_q ? S_RSP : S_IDLE;
              S_HDR: begin
                if (cnt_q == (is_ir_q ? CW'(3) : CW'(2))) begin
                  state_d = S_SHIFT;
                  cnt_d   = '0;
                end
              end
              S_SHIFT: begin
                if (cnt_q == len_m1_q) begin
                  state_d = S_TRL;
                  cnt_d   = '0;
                end
              end
              S_TRL:   if (cnt_q == CW'(1)) state_d = S_RSP;
              default: ;
            endcase
          end
        end
      end
    endcase

    case (state_d)
      S_INIT_RST: begin
        tms_d  = (cnt_d != CW'(5));
        trst_d = (cnt_d == CW'(5));
      end
      S_HDR:   tms_d = (cnt_d == '0) || (is_ir_d && cnt_d == CW'(1));
      S_SHIFT: begin
        tms_d = (cnt_d == len_m1_d);
        tdi_d = data_d[cnt_d[IW-1:0]];
      end
      S_TRL:   tms_d = (cnt_d == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      // NOTE: data and capture registers are reset too, so rsp_data reads 0 after reset.
      state_q   <= S_INIT_RST;
      cnt_q     <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trst_q    <= 1'b0;
      is_ir_q   <= 1'b0;
      rst_req_q <= 1'b0;
      err_q     <= 1'b0;
      len_m1_q  <= '0;
      data_q    <= '0;
      cap_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      trst_q    <= trst_d;
      is_ir_q   <= is_ir_d;
      rst_req_q <= rst_req_d;
      err_q     <= err_d;
      len_m1_q  <= len_m1_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RSP);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_RSP);
  assign rsp_data_o   = cap_q;
  assign rsp_err_o    = err_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Bench for jtag_scan_ctrl: directed and randomized scans compared against a
// pin-sequence model built from the TAP walk rules (TMS/TDI/TRST per TCK pulse).
module tb_jtag_scan_ctrl;
  localparam int MAX_LEN = 64;
  localparam int CLK_DIV = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int TIMEOUT = 2000;

  typedef enum int {TDO_LOOP, TDO_ZERO, TDO_INV} tdo_mode_e;

  logic               clk       = 1'b0;
  logic               reset     = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_reset = 1'b0;
  logic               req_is_ir = 1'b0;
  logic [LW-1:0]      req_len   = '0;
  logic [MAX_LEN-1:0] req_data  = '0;
  logic               rsp_ready = 1'b0;
  logic               req_ready, rsp_valid, rsp_err, busy;
  logic               tck, tms, tdi, trst_n, tdo;
  logic [MAX_LEN-1:0] rsp_data;
  tdo_mode_e          tdo_mode = TDO_LOOP;

  int n_checks = 0;
  int n_fail   = 0;
  bit tms_tr[$];
  bit tdi_tr[$];
  bit trst_tr[$];

  always #5 clk = ~clk;

  assign tdo = (tdo_mode == TDO_LOOP) ? tdi : (tdo_mode == TDO_INV) ? ~tdi : 1'b0;

  jtag_scan_ctrl #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_reset_i  (req_reset),
    .req_is_ir_i  (req_is_ir),
    .req_len_i    (req_len),
    .req_data_i   (req_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .jtag_tck_o   (tck),
    .jtag_tms_o   (tms),
    .jtag_tdi_o   (tdi),
    .jtag_trst_no (trst_n),
    .jtag_tdo_i   (tdo)
  );

  // Pin values seen by the TAP at every TCK rising edge.
  always @(posedge tck) begin
    tms_tr.push_back(tms);
    tdi_tr.push_back(tdi);
    trst_tr.push_back(trst_n);
  end

  task automatic clear_traces();
    tms_tr.delete();
    tdi_tr.delete();
    trst_tr.delete();
  endtask

  // Issues one request from a negedge and returns the edge count from the
  // acceptance edge (counted as 1) to the edge that raised rsp_valid.
  task automatic send_req(input bit rst, input bit ir, input int len,
                          input logic [MAX_LEN-1:0] data, output int lat);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
      lat = -1;
      return;
    end
    clear_traces();
    req_valid = 1'b1;
    req_reset = rst;
    req_is_ir = ir;
    req_len   = LW'(len);
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int  t;
    int  diff;
    bit  seen_rsp;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy} !== 8'b0100_0001) begin
      n_fail++;
      $display("FAIL reset_pins: tck/tms/tdi/trst/rdy/vld/err/busy=%b required 01000001",
               {tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy});
    end
    n_checks++;
    if (rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rsp_data=%h required 0", rsp_data);
    end
    reset = 1'b0;
    clear_traces();
    t = 0;
    seen_rsp = 1'b0;
    while (req_ready !== 1'b1 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
      if (rsp_valid === 1'b1) seen_rsp = 1'b1;
    end
    n_checks++;
    if (t != 2 * CLK_DIV * 6) begin
      n_fail++;
      $display("FAIL reset_ready_delay: got %0d clocks required %0d", t, 2 * CLK_DIV * 6);
    end
    n_checks++;
    if (seen_rsp) begin
      n_fail++;
      $display("FAIL reset_no_rsp: rsp_valid=1 required 0");
    end
    n_checks++;
    if (tms_tr.size() != 6) begin
      n_fail++;
      $display("FAIL reset_pulses: got %0d required 6", tms_tr.size());
    end
    diff = -1;
    for (int i = 0; i < tms_tr.size() && i < 6; i++)
      if (diff < 0 && (tms_tr[i] != (i < 5) || trst_tr[i] != (i == 5) || tdi_tr[i] != 1'b0))
        diff = i;
    n_checks++;
    if (diff >= 0) begin
      n_fail++;
      $display("FAIL reset_trace: pulse %0d tms/tdi/trst=%b%b%b required %b0%b", diff,
               tms_tr[diff], tdi_tr[diff], trst_tr[diff], diff < 5, diff == 5);
    end
    n_checks++;
    if ({tck, tms, tdi, trst_n, busy, rsp_valid} !== 6'b0001_00) begin
      n_fail++;
      $display("FAIL idle_pins: tck/tms/tdi/trst/busy/vld=%b required 000100",
               {tck, tms, tdi, trst_n, busy, rsp_valid});
    end
  endtask

  task automatic test_scan(input string name, input bit rst, input bit ir, input int len,
                           input logic [MAX_LEN-1:0] data, input tdo_mode_e mode,
                           input int hold);
    bit                 e_tms[$];
    bit                 e_tdi[$];
    bit                 e_trst[$];
    logic [MAX_LEN-1:0] e_data;
    logic [MAX_LEN-1:0] mask;
    bit                 illegal;
    int                 lat, e_lat, diff;

    illegal = !rst && (len < 1 || len > MAX_LEN);
    e_data  = '0;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        e_tms.push_back(i < 5);
        e_tdi.push_back(1'b0);
        e_trst.push_back(i == 5);
      end
    end else if (!illegal) begin
      e_tms.push_back(1'b1);
      if (ir) e_tms.push_back(1'b1);
      e_tms.push_back(1'b0);
      e_tms.push_back(1'b0);
      repeat (ir ? 4 : 3) begin
        e_tdi.push_back(1'b0);
        e_trst.push_back(1'b1);
      end
      for (int i = 0; i < len; i++) begin
        e_tms.push_back(i == len - 1);
        e_tdi.push_back(data[i]);
        e_trst.push_back(1'b1);
      end
      e_tms.push_back(1'b1);
      e_tms.push_back(1'b0);
      repeat (2) begin
        e_tdi.push_back(1'b0);
        e_trst.push_back(1'b1);
      end
      mask = {MAX_LEN{1'b1}} >> (MAX_LEN - len);
      case (mode)
        TDO_LOOP: e_data = data & mask;
        TDO_INV:  e_data = ~data & mask;
        default:  e_data = '0;
      endcase
    end
    e_lat = illegal ? 1 : 1 + 2 * CLK_DIV * e_tms.size();

    tdo_mode = mode;
    send_req(rst, ir, len, data, lat);
    if (lat < 0) return;

    n_checks++;
    if (lat != e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, e_lat);
    end
    n_checks++;
    if (rsp_err !== illegal) begin
      n_fail++;
      $display("FAIL %s err: got %b required %b", name, rsp_err, illegal);
    end
    n_checks++;
    if (rsp_data !== e_data) begin
      n_fail++;
      $display("FAIL %s data: got %h required %h", name, rsp_data, e_data);
    end
    n_checks++;
    if ({busy, req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s rsp_flags: busy/ready=%b required 00", name, {busy, req_ready});
    end
    n_checks++;
    if (tms_tr.size() != e_tms.size()) begin
      n_fail++;
      $display("FAIL %s pulses: got %0d required %0d", name, tms_tr.size(), e_tms.size());
    end
    diff = -1;
    for (int i = 0; i < e_tms.size() && i < tms_tr.size(); i++)
      if (diff < 0 && (tms_tr[i] != e_tms[i] || tdi_tr[i] != e_tdi[i] || trst_tr[i] != e_trst[i]))
        diff = i;
    n_checks++;
    if (diff >= 0) begin
      n_fail++;
      $display("FAIL %s pins: pulse %0d tms/tdi/trst=%b%b%b required %b%b%b", name, diff,
               tms_tr[diff], tdi_tr[diff], trst_tr[diff], e_tms[diff], e_tdi[diff], e_trst[diff]);
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_data} !== {1'b1, 1'b0, illegal, e_data}) begin
        n_fail++;
        $display("FAIL %s hold: cycle %0d vld/rdy/err=%b data=%h required 10%b data=%h", name, c,
                 {rsp_valid, req_ready, rsp_err}, rsp_data, illegal, e_data);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s release: vld/rdy=%b required 01", name, {rsp_valid, req_ready});
    end
  endtask

  task automatic test_illegal();
    test_scan("len0", 1'b0, 1'b0, 0, 64'hFFFF_0000_FFFF_0000, TDO_LOOP, 2);
    test_scan("len65", 1'b0, 1'b1, MAX_LEN + 1, 64'h1234_5678_9ABC_DEF0, TDO_LOOP, 0);
  endtask

  task automatic test_tap_reset();
    test_scan("tap_reset", 1'b1, 1'b0, MAX_LEN + 1, {$urandom, $urandom}, TDO_LOOP, 1);
  endtask

  task automatic test_random();
    int sel, len;
    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 9);
      len = (sel == 1) ? $urandom_range(MAX_LEN + 1, (1 << LW) - 1) : $urandom_range(1, MAX_LEN);
      test_scan($sformatf("rand%0d", k), sel == 0, $urandom_range(0, 1) == 1, len,
                {$urandom, $urandom}, tdo_mode_e'($urandom_range(0, 2)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    test_scan("b2b_ir", 1'b0, 1'b1, 1, 64'h1, TDO_INV, 0);
    test_scan("b2b_dr", 1'b0, 1'b0, 2, 64'h2, TDO_LOOP, 0);
    test_scan("b2b_max_ir", 1'b0, 1'b1, MAX_LEN, 64'hDEAD_BEEF_CAFE_F00D, TDO_INV, 0);
  endtask

  task automatic test_mid_reset();
    int t, diff;
    bit seen_rsp;
    tdo_mode = TDO_LOOP;
    clear_traces();
    req_valid = 1'b1;
    req_reset = 1'b0;
    req_is_ir = 1'b0;
    req_len   = LW'(8);
    req_data  = 64'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (tms_tr.size() < 6 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (tms_tr.size() != 6) begin
      n_fail++;
      $display("FAIL midrst_reach: pulses=%0d required 6", tms_tr.size());
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy} !== 8'b0100_0001) begin
      n_fail++;
      $display("FAIL midrst_pins: tck/tms/tdi/trst/rdy/vld/err/busy=%b required 01000001",
               {tck, tms, tdi, trst_n, req_ready, rsp_valid, rsp_err, busy});
    end
    clear_traces();
    t = 0;
    seen_rsp = 1'b0;
    while (req_ready !== 1'b1 && t < TIMEOUT) begin
      @(negedge clk);
      t++;
      if (rsp_valid === 1'b1) seen_rsp = 1'b1;
    end
    n_checks++;
    if (t != 2 * CLK_DIV * 6 || seen_rsp) begin
      n_fail++;
      $display("FAIL midrst_init: ready after %0d clocks rsp_seen=%b required %0d and 0",
               t, seen_rsp, 2 * CLK_DIV * 6);
    end
    diff = (tms_tr.size() == 6) ? -1 : 0;
    for (int i = 0; i < tms_tr.size() && i < 6; i++)
      if (diff < 0 && (tms_tr[i] != (i < 5) || trst_tr[i] != (i == 5))) diff = i;
    n_checks++;
    if (diff >= 0) begin
      n_fail++;
      $display("FAIL midrst_trace: %0d pulses, first bad pulse %0d, required 6 pulses tms 111110",
               tms_tr.size(), diff);
    end
    test_scan("dr_after_reset", 1'b0, 1'b0, 8, 64'hC3, TDO_LOOP, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan("dr_a5", 1'b0, 1'b0, 8, 64'hA5, TDO_LOOP, 0);
    test_scan("ir_1f", 1'b0, 1'b1, 5, 64'h1F, TDO_ZERO, 0);
    test_scan("dr_full_hold", 1'b0, 1'b0, MAX_LEN, 64'h0123_4567_89AB_CDEF, TDO_LOOP, 10);
    test_illegal();
    test_tap_reset();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
